// File: rtl/kda_chunk_sequencer.sv
// Key-derivation chunk sequencer: runs one shared pbkdf2 core once per output
// chunk and assembles up to four 256-bit hashes into a 1024-bit result.
module kda_chunk_sequencer #(
    parameter int HASH_W     = 256,
    parameter int MAX_CHUNKS = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         req_v_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_chunks_i,
    input  logic [5:0]                   req_salt_len_i,
    input  logic [31:0]                  req_iters_i,
    input  logic [511:0]                 req_pass_i,
    input  logic [511:0]                 req_salt_i,
    output logic                         core_v_o,
    input  logic                         core_ready_i,
    output logic [5:0]                   core_salt_len_o,
    output logic [31:0]                  core_iters_o,
    output logic [511:0]                 core_pass_o,
    output logic [511:0]                 core_salt_o,
    input  logic                         core_v_i,
    output logic                         core_ready_o,
    input  logic [HASH_W-1:0]            core_hash_i,
    output logic [HASH_W*MAX_CHUNKS-1:0] hash_o,
    output logic [1:0]                   chunks_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic                         busy_o,
    output logic [1:0]                   chunk_idx_o,
    output logic [31:0]                  cycles_o
);

    localparam int RES_W = HASH_W * MAX_CHUNKS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_chunks;
    logic [1:0]         r_idx;
    logic [5:0]         r_salt_len;
    logic [31:0]        r_iters;
    logic [511:0]       r_pass;
    logic [511:0]       r_salt;
    logic [RES_W-1:0]   r_hash;
    logic [31:0]        r_cycles;
    logic [31:0]        w_cycles_inc;
    logic [511:0]       w_salt_off;
    logic               w_last;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    assign w_last = (r_idx == r_chunks);

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_v_i)      w_next = S_ISSUE;
            S_ISSUE: if (core_ready_i) w_next = S_WAIT;
            S_WAIT:  if (core_v_i)     w_next = w_last ? S_DONE : S_ISSUE;
            S_DONE:  if (yumi_i)       w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    assign w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;
    assign w_salt_off   = {{509{1'b0}}, {1'b0, r_idx} + 3'd1};

    // NOTE: the wide request and result registers are cleared on reset too; a plain
    // RAM would not be, but these feed outputs whose reset value is observable.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_chunks   <= '0;
            r_idx      <= '0;
            r_salt_len <= '0;
            r_iters    <= '0;
            r_pass     <= '0;
            r_salt     <= '0;
            r_hash     <= '0;
            r_cycles   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_v_i) begin
                    r_chunks   <= req_chunks_i;
                    r_salt_len <= req_salt_len_i;
                    r_iters    <= req_iters_i;
                    r_pass     <= req_pass_i;
                    r_salt     <= req_salt_i;
                    r_idx      <= '0;
                    r_hash     <= '0;
                    r_cycles   <= 32'd1;
                end
                S_ISSUE: r_cycles <= w_cycles_inc;
                S_WAIT: begin
                    r_cycles <= w_cycles_inc;
                    if (core_v_i) begin
                        // Chunk 0 lands in the most significant slot.
                        for (int k = 0; k < MAX_CHUNKS; k++) begin
                            if (r_idx == 2'(k)) r_hash[RES_W-1-k*HASH_W -: HASH_W] <= core_hash_i;
                        end
                        if (!w_last) r_idx <= r_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o     = (r_state == S_IDLE);
    assign busy_o          = (r_state != S_IDLE);
    assign core_v_o        = (r_state == S_ISSUE);
    assign core_ready_o    = (r_state == S_WAIT);
    assign v_o             = (r_state == S_DONE);
    assign core_salt_len_o = r_salt_len;
    assign core_iters_o    = r_iters;
    assign core_pass_o     = r_pass;
    assign core_salt_o     = r_salt + w_salt_off;
    assign hash_o          = r_hash;
    assign chunks_o        = r_chunks;
    assign chunk_idx_o     = r_idx;
    assign cycles_o        = r_cycles;

endmodule

// File: tb/tb_kda_chunk_sequencer.sv
// Directed scoreboard bench for kda_chunk_sequencer: a scripted core model
// answers each job while expected salts and results are queued and compared.
module tb_kda_chunk_sequencer;

    logic           clk_i = 1'b0;
    logic           reset_ni;
    logic           req_v_i;
    logic           req_ready_o;
    logic [1:0]     req_chunks_i;
    logic [5:0]     req_salt_len_i;
    logic [31:0]    req_iters_i;
    logic [511:0]   req_pass_i;
    logic [511:0]   req_salt_i;
    logic           core_v_o;
    logic           core_ready_i;
    logic [5:0]     core_salt_len_o;
    logic [31:0]    core_iters_o;
    logic [511:0]   core_pass_o;
    logic [511:0]   core_salt_o;
    logic           core_v_i;
    logic           core_ready_o;
    logic [255:0]   core_hash_i;
    logic [1023:0]  hash_o;
    logic [1:0]     chunks_o;
    logic           v_o;
    logic           yumi_i;
    logic           busy_o;
    logic [1:0]     chunk_idx_o;
    logic [31:0]    cycles_o;

    kda_chunk_sequencer dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_chunks_i(req_chunks_i),
        .req_salt_len_i(req_salt_len_i), .req_iters_i(req_iters_i),
        .req_pass_i(req_pass_i), .req_salt_i(req_salt_i),
        .core_v_o(core_v_o), .core_ready_i(core_ready_i),
        .core_salt_len_o(core_salt_len_o), .core_iters_o(core_iters_o),
        .core_pass_o(core_pass_o), .core_salt_o(core_salt_o),
        .core_v_i(core_v_i), .core_ready_o(core_ready_o), .core_hash_i(core_hash_i),
        .hash_o(hash_o), .chunks_o(chunks_o), .v_o(v_o), .yumi_i(yumi_i),
        .busy_o(busy_o), .chunk_idx_o(chunk_idx_o), .cycles_o(cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1023:0] hash;
        logic [1:0]    chunks;
        logic [31:0]   cycles;
    } res_t;

    logic [511:0] exp_salt_q[$];
    res_t         exp_res_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;
    logic [511:0] cur_pass;
    logic [31:0]  cur_iters;
    logic [5:0]   cur_salt_len;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One core job: hold off ready for rdly cycles, accept, then answer after wdly WAIT cycles.
    task automatic do_chunk(input int k, input logic [255:0] h, input int rdly, input int wdly,
                            input bit spur, input bit yumi_w);
        logic [511:0] es;
        check("core_v_o_issue", 512'(core_v_o), 512'(1));
        check("chunk_idx", 512'(chunk_idx_o), 512'(k));
        for (int d = 0; d < rdly; d++) begin
            core_ready_i = 1'b0;
            core_v_i     = spur;
            core_hash_i  = '1;
            tick();
            check("core_v_o_held", 512'(core_v_o), 512'(1));
            check("core_salt_held", core_salt_o, exp_salt_q[0]);
        end
        core_v_i     = spur;
        core_hash_i  = '1;
        core_ready_i = 1'b1;
        es = exp_salt_q.pop_front();
        check("core_salt", core_salt_o, es);
        check("core_pass", core_pass_o, cur_pass);
        check("core_iters", 512'(core_iters_o), 512'(cur_iters));
        check("core_salt_len", 512'(core_salt_len_o), 512'(cur_salt_len));
        tick();
        core_ready_i = 1'b0;
        core_v_i     = 1'b0;
        check("core_v_o_drop", 512'(core_v_o), 512'(0));
        check("core_ready_o", 512'(core_ready_o), 512'(1));
        for (int d = 0; d < wdly; d++) begin
            yumi_i = yumi_w && (d == 0);
            tick();
            yumi_i = 1'b0;
        end
        if (yumi_w) check("yumi_in_wait_ignored", 512'(core_ready_o), 512'(1));
        core_v_i    = 1'b1;
        core_hash_i = h;
        tick();
        core_v_i = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] ch, input logic [511:0] salt);
        cur_pass     = {16{$urandom}};
        cur_iters    = $urandom;
        cur_salt_len = 6'($urandom);
        check("req_ready_idle", 512'(req_ready_o), 512'(1));
        req_v_i        = 1'b1;
        req_chunks_i   = ch;
        req_salt_i     = salt;
        req_pass_i     = cur_pass;
        req_iters_i    = cur_iters;
        req_salt_len_i = cur_salt_len;
        tick();
        req_v_i    = 1'b0;
        req_pass_i = '0;
        req_salt_i = '0;
        check("busy_accept", 512'(busy_o), 512'(1));
        check("hash_cleared_hi", hash_o[1023:512], '0);
        check("hash_cleared_lo", hash_o[511:0], '0);
        check("cycles_start", 512'(cycles_o), 512'(1));
    endtask

    task automatic run_req(input logic [1:0] ch, input logic [511:0] salt, input logic [3:0][255:0] hs,
                           input int rdly, input int wdly, input bit spur, input bit yumi_w);
        res_t r;
        r.hash   = '0;
        r.chunks = ch;
        r.cycles = 32'(1 + (int'(ch) + 1) * (rdly + wdly + 2));
        for (int k = 0; k <= int'(ch); k++) begin
            exp_salt_q.push_back(salt + 512'(k + 1));
            r.hash[1023-256*k -: 256] = hs[k];
        end
        exp_res_q.push_back(r);
        drive_req(ch, salt);
        for (int k = 0; k <= int'(ch); k++) do_chunk(k, hs[k], rdly, wdly, spur, yumi_w);
    endtask

    task automatic finish_req(input int ydly);
        res_t r;
        check("v_o_done", 512'(v_o), 512'(1));
        r = exp_res_q.pop_front();
        for (int k = 0; k < 4; k++) check("hash_slot", 512'(hash_o[1023-256*k -: 256]), 512'(r.hash[1023-256*k -: 256]));
        check("chunks_o", 512'(chunks_o), 512'(r.chunks));
        check("cycles_o", 512'(cycles_o), 512'(r.cycles));
        for (int i = 0; i < ydly; i++) begin
            tick();
            check("v_o_held", 512'(v_o), 512'(1));
            check("cycles_frozen", 512'(cycles_o), 512'(r.cycles));
        end
        yumi_i = 1'b1;
        check("req_ready_in_done", 512'(req_ready_o), 512'(0));
        tick();
        yumi_i = 1'b0;
        check("req_ready_after_yumi", 512'(req_ready_o), 512'(1));
        check("v_o_after_yumi", 512'(v_o), 512'(0));
        check("busy_after_yumi", 512'(busy_o), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0][255:0] hs;
        reset_ni = 1'b0; req_v_i = 1'b0; req_chunks_i = '0; req_salt_len_i = '0;
        req_iters_i = '0; req_pass_i = '0; req_salt_i = '0; core_ready_i = 1'b0;
        core_v_i = 1'b0; core_hash_i = '0; yumi_i = 1'b0;
        tick(); tick();
        check("rst_req_ready", 512'(req_ready_o), 512'(1));
        check("rst_busy", 512'(busy_o), 512'(0));
        check("rst_core_v", 512'(core_v_o), 512'(0));
        check("rst_v_o", 512'(v_o), 512'(0));
        check("rst_cycles", 512'(cycles_o), 512'(0));
        @(negedge clk_i) reset_ni = 1'b1;
        tick();

        // Single chunk, 5-cycle core response.
        hs = '0; hs[0] = {32{8'hAA}};
        run_req(2'd0, 512'h10, hs, 0, 4, 1'b0, 1'b0);
        finish_req(0);

        // Four chunks filled high to low.
        hs[0] = {64{4'h1}}; hs[1] = {64{4'h2}}; hs[2] = {64{4'h3}}; hs[3] = {64{4'h4}};
        run_req(2'd3, 512'h20, hs, 1, 2, 1'b0, 1'b0);
        finish_req(0);

        // Salt wraps modulo 2^512.
        hs = '0; hs[0] = 256'hDEAD; hs[1] = 256'hBEEF;
        run_req(2'd1, '1, hs, 0, 0, 1'b0, 1'b0);
        finish_req(1);

        // Core stalls 10 cycles with spurious core_v_i; yumi_i pulsed in WAIT.
        hs = '0; hs[0] = {8{32'h0BAD_F00D}};
        run_req(2'd0, 512'h55, hs, 10, 2, 1'b1, 1'b1);
        finish_req(0);

        // Back-to-back with delayed consume; second request must start from a cleared result.
        hs[0] = {16{16'h1234}}; hs[1] = {16{16'h5678}}; hs[2] = {16{16'h9ABC}}; hs[3] = '0;
        run_req(2'd2, 512'h1000, hs, 0, 1, 1'b0, 1'b0);
        finish_req(3);
        hs[0] = {16{16'h0F0F}}; hs[1] = '0; hs[2] = '0; hs[3] = '0;
        run_req(2'd0, 512'h2000, hs, 2, 0, 1'b0, 1'b0);
        finish_req(3);

        // Asynchronous reset mid-WAIT on a four-chunk job.
        hs[0] = {8{32'hCAFE_0001}};
        exp_salt_q.push_back(512'h31);
        exp_salt_q.push_back(512'h32);
        drive_req(2'd3, 512'h30);
        do_chunk(0, hs[0], 0, 1, 1'b0, 1'b0);
        check("pre_rst_slot0", 512'(hash_o[1023:768]), 512'(hs[0]));
        core_ready_i = 1'b1;
        check("pre_rst_salt", core_salt_o, exp_salt_q.pop_front());
        exp_salt_q.pop_front();
        tick();
        core_ready_i = 1'b0;
        check("pre_rst_wait", 512'(core_ready_o), 512'(1));
        #2 reset_ni = 1'b0;
        #1;
        check("async_busy", 512'(busy_o), 512'(0));
        check("async_req_ready", 512'(req_ready_o), 512'(1));
        check("async_core_ready", 512'(core_ready_o), 512'(0));
        check("async_hash_hi", hash_o[1023:512], '0);
        check("async_cycles", 512'(cycles_o), 512'(0));
        check("async_idx", 512'(chunk_idx_o), 512'(0));
        check("async_chunks", 512'(chunks_o), 512'(0));
        exp_salt_q.delete();
        exp_res_q.delete();
        @(negedge clk_i) reset_ni = 1'b1;
        tick();
        check("post_rst_req_ready", 512'(req_ready_o), 512'(1));
        check("post_rst_busy", 512'(busy_o), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
